mem_access_unit: RTL and testbench

Initiator side of the DataMemory port (clk, write_enable, address, write_data, write_mask, read_data). Sits between the execute stage and DataMemory. Takes RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and generates word-aligned addresses, byte masks and lane-shifted store data. Extracts and sign- or zero-extends load data, splits word-crossing accesses into two memory cycles, and returns a one-cycle response.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// RV32 load/store initiator for the DataMemory port: lane steering, extension, word-crossing split.
// Optional MISALIGNED_SPLIT_EN: split word-crossing accesses into two cycles; otherwise they raise resp_error.
module mem_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_address,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic [3:0]      mem_write_mask,
    input  logic [XLEN-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q;
    logic              write_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [XLEN-1:0]   wdata_q;
    logic              spans_q;
    logic              err_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   hi_q;

    logic [2:0]        req_size;
    logic              req_legal;
    logic              req_spans;
    logic              req_err;
    logic [3:0]        size_mask;
    logic [XLEN-1:0]   wdata_m;
    logic [7:0]        mask8;
    logic [63:0]       data64;
    logic              acc_hi;
    logic              active;
    logic [3:0]        lane_mask;

    function automatic logic [31:0] extract(
        input logic [63:0] dw,
        input logic [1:0]  off,
        input logic [2:0]  f3
    );
        logic [63:0] sh;
        logic [31:0] r;
        sh = dw >> {off, 3'b000};
        unique case (f3[1:0])
            2'b00:   r = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
            2'b01:   r = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
            default: r = sh[31:0];
        endcase
        return r;
    endfunction

    always_comb begin
        req_size = 3'd4;
        unique case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
    end

    always_comb begin
        req_legal = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_write;
            default:                req_legal = 1'b0;
        endcase
    end

    assign req_spans = ({1'b0, req_address[1:0]} + req_size) > 3'd4;

`ifdef MISALIGNED_SPLIT_EN
    assign req_err = !req_legal;
    assign acc_hi  = (state_q == ACC1);
`else
    assign req_err = !req_legal || req_spans;
    assign acc_hi  = 1'b0;
`endif

    // Lanes are built on a 64-bit window so the split half falls out of the top word.
    always_comb begin
        size_mask = 4'b1111;
        wdata_m   = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                size_mask = 4'b0001;
                wdata_m   = {24'b0, wdata_q[7:0]};
            end
            2'b01: begin
                size_mask = 4'b0011;
                wdata_m   = {16'b0, wdata_q[15:0]};
            end
            default: ;
        endcase
        mask8  = {4'b0000, size_mask} << off_q;
        data64 = {32'b0, wdata_m} << {off_q, 3'b000};
    end

    assign active    = ((state_q == ACC0) && !err_q) || acc_hi;
    assign lane_mask = acc_hi ? mask8[7:4] : mask8[3:0];

    assign mem_address      = addr_q;
    assign mem_write_mask   = active ? lane_mask : 4'b0000;
    assign mem_write_data   = !active ? '0
                            : acc_hi ? data64[63:32] : data64[31:0];
    assign mem_write_enable = active && write_q && (|lane_mask) && reset;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_error = (state_q == RESP) && err_q;
    assign resp_rdata = ((state_q == RESP) && !err_q && !write_q)
                      ? extract({hi_q, lo_q}, off_q, f3_q) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            wdata_q <= '0;
            spans_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        f3_q    <= req_funct3;
                        off_q   <= req_address[1:0];
                        wdata_q <= req_wdata;
                        spans_q <= req_spans;
                        err_q   <= req_err;
                        state_q <= ACC0;
                        if (!req_err) begin
                            addr_q <= {req_address[XLEN-1:2], 2'b00};
                        end
                    end
                end
                ACC0: begin
                    if (!write_q) begin
                        lo_q <= mem_read_data;
                    end
`ifdef MISALIGNED_SPLIT_EN
                    if (spans_q && !err_q) begin
                        addr_q  <= addr_q + 32'd4;
                        state_q <= ACC1;
                    end else begin
                        state_q <= RESP;
                    end
`else
                    state_q <= RESP;
`endif
                end
`ifdef MISALIGNED_SPLIT_EN
                ACC1: begin
                    if (!write_q) begin
                        hi_q <= mem_read_data;
                    end
                    state_q <= RESP;
                end
`endif
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory, directed cases, random requests.
// Adapts its expectations to MISALIGNED_SPLIT_EN.
module tb_mem_access_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit [31:0] a;
        bit [3:0]  m;
        bit [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] dmem [256];
    bit [7:0]    ref_mem [bit [31:0]];

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_mask   (mem_write_mask),
        .mem_read_data    (mem_read_data)
    );

    assign mem_read_data = dmem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            wr_q.push_back('{mem_address, mem_write_mask, mem_write_data});
            for (int b = 0; b < 4; b++) begin
                if (mem_write_mask[b]) begin
                    dmem[mem_address[9:2]][8*b +: 8] = mem_write_data[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] rb(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int sz(input bit [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit legal(input bit w, input bit [2:0] f3);
        if (w) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
        return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    endfunction

    task automatic do_req(input bit w, input bit [2:0] f3,
                          input bit [31:0] a, input bit [31:0] wd);
        int        size;
        int        n;
        int        lat;
        int        lane;
        bit        err;
        bit        spans;
        bit        got;
        bit        have;
        bit [31:0] v;
        bit [31:0] erd;
        bit [31:0] ba;
        bit [31:0] wa;
        wr_t       cur;
        wr_t       exp[$];

        size  = sz(f3);
        spans = (int'(a[1:0]) + size) > 4;
        err   = !legal(w, f3) || (spans && !SPLIT);
        lat   = (spans && !err) ? 2 : 1;
        erd   = 32'h0;
        have  = 1'b0;
        cur   = '{32'h0, 4'h0, 32'h0};
        if (!err && !w) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rb(a + i);
            erd = v;
            if (!f3[2] && size == 1) erd = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) erd = {{16{v[15]}}, v[15:0]};
        end
        if (!err && w) begin
            for (int i = 0; i < size; i++) begin
                ba   = a + i;
                wa   = ba & ~32'h3;
                lane = int'(ba[1:0]);
                if (have && cur.a != wa) begin
                    exp.push_back(cur);
                    have = 1'b0;
                end
                if (!have) begin
                    cur  = '{wa, 4'h0, 32'h0};
                    have = 1'b1;
                end
                cur.m[lane]        = 1'b1;
                cur.d[8*lane +: 8] = wd[8*i +: 8];
                ref_mem[ba]        = wd[8*i +: 8];
            end
            if (have) exp.push_back(cur);
        end

        @(negedge clk);
        chk("rdy", 32'(req_ready), 32'd1);
        wr_q.delete();
        req_valid   = 1'b1;
        req_write   = w;
        req_funct3  = f3;
        req_address = a;
        req_wdata   = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            @(posedge clk);
            #1;
            n++;
            got = resp_valid;
        end
        chk("lat", 32'(n), 32'(lat));
        if (got) begin
            chk("err", 32'(resp_error), 32'(err));
            chk("rdata", resp_rdata, erd);
            @(posedge clk);
            #1 chk("vld1", 32'(resp_valid), 32'd0);
        end
        chk("nwr", 32'(wr_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wr_q.size(); i++) begin
            chk("waddr", wr_q[i].a, exp[i].a);
            chk("wmask", 32'(wr_q[i].m), 32'(exp[i].m));
            chk("wdata", wr_q[i].d, exp[i].d);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'b000;
        req_address = 32'h0;
        req_wdata   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(req_ready), 32'd1);
        chk("rst_vld", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_error), 32'd0);
        chk("rst_we", 32'(mem_write_enable), 32'd0);
        chk("rst_mask", 32'(mem_write_mask), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_req(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h104, 32'h0);
        do_req(1'b1, 3'b000, 32'h107, 32'h000000CA);
        do_req(1'b0, 3'b100, 32'h107, 32'h0);
        do_req(1'b0, 3'b000, 32'h107, 32'h0);
        do_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
        do_req(1'b0, 3'b001, 32'h102, 32'h0);
        do_req(1'b0, 3'b101, 32'h102, 32'h0);
        do_req(1'b1, 3'b010, 32'h103, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h103, 32'h0);
        do_req(1'b0, 3'b011, 32'h100, 32'h0);
        do_req(1'b1, 3'b100, 32'h100, 32'h12345678);

        // Reset sampled at the end of ACC0: the store must never land.
        @(negedge clk);
        wr_q.delete();
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_funct3  = 3'b010;
        req_address = 32'h110;
        req_wdata   = 32'h55667788;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("acc0_we", 32'(mem_write_enable), 32'd1);
        reset = 1'b0;
        #1 chk("rstg_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1 chk("rstg_vld", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 chk("rstg_vld2", 32'(resp_valid), 32'd0);
        end
        chk("rstg_nwr", 32'(wr_q.size()), 32'd0);
        chk("rstg_rdy", 32'(req_ready), 32'd1);

`ifdef MISALIGNED_SPLIT_EN
        @(negedge clk);
        wr_q.delete();
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_funct3  = 3'b010;
        req_address = 32'hFFFFFFFE;
        req_wdata   = 32'hA5B6C7D8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 chk("ab_vld", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ab_rdy", 32'(req_ready), 32'd1);
        chk("ab_vld2", 32'(resp_valid), 32'd0);
        chk("ab_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) begin
            chk("ab_addr", wr_q[0].a, 32'hFFFFFFFC);
            chk("ab_mask", 32'(wr_q[0].m), 32'hC);
            chk("ab_data", wr_q[0].d, 32'hC7D80000);
        end
`else
        do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA5B6C7D8);
`endif

        for (int k = 0; k < 80; k++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'h100 + 32'($urandom_range(0, 255)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
